// File: rtl/alu_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// slc3_ctrl_pkg
// Shared definitions for the SLC3 operate-class ALU sequencer:
//   - sequencer state encoding
//   - operate-class opcodes (ADD, AND, NOT)
//   - ALUK function encodings
//   - nzp_of(): condition-code derivation from a 16-bit result
// ---------------------------------------------------------------------------
package slc3_ctrl_pkg;

    typedef enum logic [2:0] {
        HALTED,
        IDLE,
        DECODE,
        EXEC,
        WRITE,
        PAUSE
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [1:0] ALUK_ADD  = 2'b11;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b00;

    // {N,Z,P}: exactly one bit set for any 16-bit value.
    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        return {v[15], (v == '0), (!v[15] && (v != '0))};
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Instruction handshake plus ALU/register-file control bundle.
//   instr_valid, IR_in  : instruction source -> sequencer
//   instr_ready         : sequencer -> instruction source
//   ALU_out             : datapath -> sequencer (result for condition codes)
//   IR, ALUK, SR1MUX, SR2MUX, DRMUX, GateALU, LD_REG, LD_CC, NZP
//                       : sequencer -> datapath
// modport slave  : the sequencer side
// modport master : the instruction source / datapath side
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if;

    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] IR_in;
    logic [15:0] ALU_out;
    logic [15:0] IR;
    logic [1:0]  ALUK;
    logic        SR1MUX;
    logic        SR2MUX;
    logic        DRMUX;
    logic        GateALU;
    logic        LD_REG;
    logic        LD_CC;
    logic [2:0]  NZP;

    modport slave (
        input  instr_valid, IR_in, ALU_out,
        output instr_ready, IR, ALUK, SR1MUX, SR2MUX, DRMUX,
               GateALU, LD_REG, LD_CC, NZP
    );

    modport master (
        output instr_valid, IR_in, ALU_out,
        input  instr_ready, IR, ALUK, SR1MUX, SR2MUX, DRMUX,
               GateALU, LD_REG, LD_CC, NZP
    );

endinterface

// File: rtl/alu_op_sequencer_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Combinational opcode decoder for operate-class instructions.
//   i_opcode [3:0] : instruction bits [15:12]
//   i_imm          : instruction bit [5] (immediate select for ADD/AND)
//   o_aluk   [1:0] : ALU function
//   o_sr2mux       : 1 = immediate second operand
//   o_legal        : opcode is ADD, AND or NOT
// ---------------------------------------------------------------------------
module alu_op_decode
    import slc3_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_imm,
    output logic [1:0] o_aluk,
    output logic       o_sr2mux,
    output logic       o_legal
);

    always_comb begin
        o_aluk   = ALUK_PASS;
        o_sr2mux = 1'b0;
        o_legal  = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                o_aluk   = ALUK_ADD;
                o_sr2mux = i_imm;
                o_legal  = 1'b1;
            end
            OP_AND: begin
                o_aluk   = ALUK_AND;
                o_sr2mux = i_imm;
                o_legal  = 1'b1;
            end
            OP_NOT: begin
                o_aluk   = ALUK_NOT;
                o_legal  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// Multicycle controller sequencing the SLC3 ALU for ADD/AND/NOT.
// Flow: HALTED -(Run)-> IDLE -(valid)-> DECODE -> EXEC -> WRITE -> IDLE,
// or WRITE -> PAUSE -(Continue)-> IDLE when STEP_MODE=1. Illegal opcodes
// return from DECODE to IDLE with a one-cycle illegal pulse.
//
// Parameters:
//   STEP_MODE : 1 = pause after every write-back, 0 = free-running
// Ports:
//   Clk       : clock, rising edge
//   Reset     : asynchronous, active-low reset
//   Run       : leave HALTED (sampled only in HALTED)
//   Continue  : leave PAUSE (sampled only in PAUSE)
//   bus       : handshake + datapath control bundle (slave side)
//   busy      : high in DECODE, EXEC, WRITE, PAUSE
//   illegal   : one-cycle pulse during DECODE of a non-operate opcode
//   op_count  : completed-op counter
// Build option:
//   ALU_OP_SEQUENCER_STATS_EN : when defined, op_count counts WRITE cycles
//   (saturating); otherwise op_count is tied to zero.
// ---------------------------------------------------------------------------
module alu_op_sequencer
    import slc3_ctrl_pkg::*;
#(
    parameter bit STEP_MODE = 1'b0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Run,
    input  logic                  Continue,
    alu_op_sequencer_if.slave     bus,
    output logic                  busy,
    output logic                  illegal,
    output logic [15:0]           op_count
);

    state_t      r_state;
    logic [15:0] r_ir;
    logic [1:0]  r_aluk;
    logic        r_sr1mux;
    logic        r_sr2mux;
    logic        r_drmux;
    logic        r_gate;
    logic        r_ld_reg;
    logic        r_ld_cc;
    logic [2:0]  r_nzp;
    logic        r_ready;
    logic        r_busy;
    logic        r_illegal;

    logic [1:0]  w_dec_aluk;
    logic        w_dec_sr2mux;
    logic        w_dec_legal;

    // The word is decoded as it is latched so that ALUK, SR2MUX and the
    // illegal pulse are already registered during the DECODE cycle.
    alu_op_decode u_decode (
        .i_opcode (bus.IR_in[15:12]),
        .i_imm    (bus.IR_in[5]),
        .o_aluk   (w_dec_aluk),
        .o_sr2mux (w_dec_sr2mux),
        .o_legal  (w_dec_legal)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= HALTED;
            r_ir      <= '0;
            r_aluk    <= '0;
            r_sr1mux  <= 1'b0;
            r_sr2mux  <= 1'b0;
            r_drmux   <= 1'b0;
            r_gate    <= 1'b0;
            r_ld_reg  <= 1'b0;
            r_ld_cc   <= 1'b0;
            r_nzp     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                HALTED: begin
                    if (Run) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.instr_valid) begin
                        r_state   <= DECODE;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_ir      <= bus.IR_in;
                        r_aluk    <= w_dec_aluk;
                        r_sr1mux  <= 1'b1;
                        r_sr2mux  <= w_dec_sr2mux;
                        r_drmux   <= 1'b0;
                        r_illegal <= !w_dec_legal;
                    end
                end
                DECODE: begin
                    if (r_illegal) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= EXEC;
                        r_gate  <= 1'b1;
                    end
                end
                EXEC: begin
                    r_state  <= WRITE;
                    r_ld_reg <= 1'b1;
                    r_ld_cc  <= 1'b1;
                end
                WRITE: begin
                    r_nzp    <= nzp_of(bus.ALU_out);
                    r_gate   <= 1'b0;
                    r_ld_reg <= 1'b0;
                    r_ld_cc  <= 1'b0;
                    if (STEP_MODE) begin
                        r_state <= PAUSE;
                    end else begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (Continue) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= HALTED;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_OP_SEQUENCER_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_op_count <= '0;
        end else if (r_state == WRITE && r_op_count != '1) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`else
    assign op_count = '0;
`endif

    assign bus.instr_ready = r_ready;
    assign bus.IR          = r_ir;
    assign bus.ALUK        = r_aluk;
    assign bus.SR1MUX      = r_sr1mux;
    assign bus.SR2MUX      = r_sr2mux;
    assign bus.DRMUX       = r_drmux;
    assign bus.GateALU     = r_gate;
    assign bus.LD_REG      = r_ld_reg;
    assign bus.LD_CC       = r_ld_cc;
    assign bus.NZP         = r_nzp;
    assign busy            = r_busy;
    assign illegal         = r_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Scoreboard bench: dut0 free-running (STEP_MODE=0), dut1 single-step
// (STEP_MODE=1). Expected outputs for dut0 are queued at issue time and
// popped when LD_REG or illegal is observed.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
    import slc3_ctrl_pkg::*;

`ifdef ALU_OP_SEQUENCER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Run;
    logic        Continue;
    logic        busy0, illegal0, busy1, illegal1;
    logic [15:0] opc0, opc1;

    alu_op_sequencer_if b0 ();
    alu_op_sequencer_if b1 ();

    always #5 Clk = ~Clk;

    alu_op_sequencer #(.STEP_MODE(1'b0)) dut0 (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Continue (Continue),
        .bus      (b0),
        .busy     (busy0),
        .illegal  (illegal0),
        .op_count (opc0)
    );

    alu_op_sequencer #(.STEP_MODE(1'b1)) dut1 (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Continue (Continue),
        .bus      (b1),
        .busy     (busy1),
        .illegal  (illegal1),
        .op_count (opc1)
    );

    typedef struct {
        logic [15:0] ir;
        logic [15:0] alu;
        logic [1:0]  aluk;
        logic        sr2;
        logic        ill;
        int unsigned wcyc;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned last_acc = 0;
    bit          nzp_pend = 1'b0;
    bit          rdy_pend = 1'b0;
    logic [2:0]  nzp_exp = '0;

    always @(posedge Clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    endtask

    function automatic logic [1:0] m_aluk(input logic [15:0] ir);
        case (ir[15:12])
            4'h1:    return 2'b11;
            4'h5:    return 2'b01;
            4'h9:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic m_sr2(input logic [15:0] ir);
        return (ir[15:12] == 4'h1 || ir[15:12] == 4'h5) ? ir[5] : 1'b0;
    endfunction

    function automatic logic m_ill(input logic [15:0] ir);
        return !(ir[15:12] == 4'h1 || ir[15:12] == 4'h5 || ir[15:12] == 4'h9);
    endfunction

    function automatic logic [2:0] m_nzp(input logic [15:0] a);
        logic n, z, p;
        n = a[15];
        z = (a == 16'h0000);
        p = !n && !z;
        return {n, z, p};
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [15:0] ir, input logic [15:0] alu);
        int unsigned n;
        exp_t e;
        n = 0;
        b0.IR_in = ir;
        b0.instr_valid = 1'b1;
        while (!b0.instr_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!b0.instr_ready) begin
            check("accept_timeout", 32'(0), 32'(1));
            b0.instr_valid = 1'b0;
            return;
        end
        b0.ALU_out = alu;
        e.ir   = ir;
        e.alu  = alu;
        e.aluk = m_aluk(ir);
        e.sr2  = m_sr2(ir);
        e.ill  = m_ill(ir);
        e.wcyc = e.ill ? cyc + 1 : cyc + 3;
        last_acc = cyc + 1;
        sbq.push_back(e);
        @(negedge Clk);
        b0.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while ((sbq.size() != 0 || nzp_pend || rdy_pend || !b0.instr_ready) && n < 30) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 30) check("drain_timeout", 32'(0), 32'(1));
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (nzp_pend) begin
            nzp_pend = 1'b0;
            if (Reset) check("NZP", 32'(b0.NZP), 32'(nzp_exp));
        end
        if (rdy_pend) begin
            rdy_pend = 1'b0;
            check("ready_after_illegal", 32'(b0.instr_ready), 32'(1));
            check("illegal_width", 32'(illegal0), 32'(0));
        end
        if (Reset && (b0.LD_REG || illegal0)) begin
            if (sbq.size() == 0) begin
                check("sb_underflow", 32'(1), 32'(0));
            end else begin
                e = sbq.pop_front();
                check("out_cycle", cyc, e.wcyc);
                check("illegal_flag", 32'(illegal0), 32'(e.ill));
                check("IR", 32'(b0.IR), 32'(e.ir));
                if (e.ill) begin
                    check("ctl_on_illegal", 32'({b0.GateALU, b0.LD_REG, b0.LD_CC}), 32'(0));
                    rdy_pend = 1'b1;
                end else begin
                    check("ALUK", 32'(b0.ALUK), 32'(e.aluk));
                    check("SR2MUX", 32'(b0.SR2MUX), 32'(e.sr2));
                    check("SR1MUX_DRMUX", 32'({b0.SR1MUX, b0.DRMUX}), 32'(2'b10));
                    check("gate_ld", 32'({b0.GateALU, b0.LD_REG, b0.LD_CC}), 32'(3'b111));
                    nzp_exp  = m_nzp(e.alu);
                    nzp_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a1;
        int unsigned n;
        Reset = 1'b0;
        Run = 1'b0;
        Continue = 1'b0;
        b0.instr_valid = 1'b0;
        b0.IR_in = '0;
        b0.ALU_out = '0;
        b1.instr_valid = 1'b0;
        b1.IR_in = '0;
        b1.ALU_out = '0;

        // Reset values
        @(negedge Clk);
        check("rst_IR", 32'(b0.IR), 32'(0));
        check("rst_ALUK", 32'(b0.ALUK), 32'(0));
        check("rst_NZP", 32'(b0.NZP), 32'(0));
        check("rst_bits", 32'({b0.instr_ready, b0.SR1MUX, b0.SR2MUX, b0.DRMUX, b0.GateALU,
                               b0.LD_REG, b0.LD_CC, busy0, illegal0}), 32'(0));
        check("rst_op_count", 32'(opc0), 32'(0));
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("halted_no_ready", 32'(b0.instr_ready), 32'(0));
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        check("run_ready", 32'(b0.instr_ready), 32'(1));
        check("idle_not_busy", 32'(busy0), 32'(0));

        // ADD register form, zero result
        issue(16'h1283, 16'h0000);
        check("busy_decode", 32'(busy0), 32'(1));
        wait_idle();
        // AND immediate, negative result
        issue(16'h5262, 16'h8000);
        wait_idle();
        // NOT then back-to-back ADD immediate
        issue(16'h927F, 16'h0005);
        a1 = last_acc;
        issue(16'h14A1, 16'h7FFF);
        check("b2b_gap", last_acc - a1, 32'(4));
        wait_idle();
        check("op_count_4", 32'(opc0), STATS ? 32'(4) : 32'(0));

        // TRAP: illegal
        issue(16'hF025, 16'h1234);
        wait_idle();
        check("op_count_trap", 32'(opc0), STATS ? 32'(4) : 32'(0));
        check("nzp_after_trap", 32'(b0.NZP), 32'(3'b001));

        // Reset in the middle of WRITE
        issue(16'h1283, 16'h8001);
        n = 0;
        while (!b0.LD_REG && n < 10) begin
            @(negedge Clk);
            n++;
        end
        check("saw_write", 32'(b0.LD_REG), 32'(1));
        #2 Reset = 1'b0;
        #1;
        check("abort_LD_REG", 32'({b0.GateALU, b0.LD_REG, b0.LD_CC}), 32'(0));
        check("abort_NZP", 32'(b0.NZP), 32'(0));
        check("abort_IR", 32'(b0.IR), 32'(0));
        check("abort_ready_busy", 32'({b0.instr_ready, busy0}), 32'(0));
        check("abort_op_count", 32'(opc0), 32'(0));
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("halted_after_reset", 32'(b0.instr_ready), 32'(0));
        check("nzp_held_zero", 32'(b0.NZP), 32'(0));
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        check("rerun_ready", 32'(b0.instr_ready), 32'(1));

        // Single-step instance
        for (int i = 0; i < 3; i++) begin
            check("s_ready", 32'(b1.instr_ready), 32'(1));
            b1.IR_in = 16'h1283;
            b1.ALU_out = 16'h0002;
            b1.instr_valid = 1'b1;
            @(negedge Clk);
            b1.instr_valid = 1'b0;
            @(negedge Clk);
            check("s_exec_gate", 32'({b1.GateALU, b1.LD_REG}), 32'(2'b10));
            @(negedge Clk);
            check("s_write", 32'({b1.GateALU, b1.LD_REG, b1.LD_CC}), 32'(3'b111));
            Continue = 1'b1;
            @(negedge Clk);
            Continue = 1'b0;
            check("s_pause", 32'({b1.instr_ready, busy1, b1.LD_REG}), 32'(3'b010));
            check("s_nzp", 32'(b1.NZP), 32'(3'b001));
            repeat (3) @(negedge Clk);
            check("s_hold", 32'(b1.instr_ready), 32'(0));
            Continue = 1'b1;
            @(negedge Clk);
            Continue = 1'b0;
            check("s_resume", 32'({b1.instr_ready, busy1}), 32'(2'b10));
        end
        check("s_op_count", 32'(opc1), STATS ? 32'(3) : 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multicycle controller that sequences the SLC3 ALU for operate-class instructions (ADD, AND, NOT).
- Accepts one instruction word per valid/ready handshake, latches it and decodes the opcode.
- Drives the ALU and register-file control lines (ALUK, SR1MUX, SR2MUX, DRMUX, GateALU, LD_REG, LD_CC) and holds the NZP condition codes.
- Sits between the instruction source and the ALU/register-file datapath; supports Run/Continue single-step debug.

Parameters:
STEP_MODE, 0, 1 = enter PAUSE after every write-back and wait for Continue; 0 = free-running.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
Run  input  1  start; level sampled in HALTED
Continue  input  1  resume from PAUSE; level sampled in PAUSE
instr_valid  input  1  IR_in valid
instr_ready  output  1  sequencer can accept an instruction
IR_in  input  16  incoming instruction word
ALU_out  input  16  ALU result, used for condition codes
IR  output  16  latched instruction, feeds the datapath
ALUK  output  2  ALU function: 11 ADD, 01 AND, 10 NOT, 00 PASS
SR1MUX  output  1  1 = SR1 from IR[8:6]
SR2MUX  output  1  1 = immediate operand (IR[5] for ADD/AND)
DRMUX  output  1  0 = DR from IR[11:9]
GateALU  output  1  drive ALU result onto the bus
LD_REG  output  1  register-file write enable
LD_CC  output  1  condition-code load strobe
NZP  output  3  condition codes {N,Z,P}
busy  output  1  high in DECODE, EXEC, WRITE and PAUSE
illegal  output  1  one-cycle pulse when the opcode is not ADD, AND or NOT
op_count  output  16  completed-op counter (optional feature)

Behaviour:
- Reset low, asynchronous:
  - State goes to HALTED.
  - IR, ALUK, NZP and op_count clear to 0.
  - All single-bit outputs go to 0.
  - A reset mid-instruction aborts it with no LD_REG.
- States: HALTED, IDLE, DECODE, EXEC, WRITE, PAUSE.
- HALTED: instr_ready=0. Moves to IDLE on the first cycle with Run=1.
- IDLE: instr_ready=1. When instr_valid=1, latch IR<=IR_in and go to DECODE. Without valid, stay in IDLE.
- DECODE:
  - Register ALUK from IR[15:12]: 0001->11, 0101->01, 1001->10, otherwise 00.
  - SR1MUX=1 and DRMUX=0 for all opcodes.
  - SR2MUX=IR[5] for ADD/AND; SR2MUX=0 for NOT.
  - Legal opcode: go to EXEC.
  - Illegal opcode: pulse illegal for this cycle, make no datapath writes, return to IDLE.
- EXEC: GateALU=1 for one settle cycle, then go to WRITE.
- WRITE:
  - GateALU=1, LD_REG=1, LD_CC=1 for exactly one cycle.
  - At the clock edge ending WRITE, NZP <= {ALU_out[15], ALU_out==0, !ALU_out[15] && ALU_out!=0}. Exactly one NZP bit is set after the first op.
  - Next state: PAUSE if STEP_MODE=1, else IDLE.
- PAUSE: instr_ready=0. Go to IDLE on a cycle where Continue=1. Continue asserted during WRITE is ignored.
- Latency: handshake accepted at edge t gives DECODE t+1, EXEC t+2, WRITE t+3. instr_ready returns at t+4, so throughput is 1 instruction per 4 cycles (STEP_MODE=0).
- Between ops: ALUK and the mux selects hold their last value; GateALU, LD_REG and LD_CC are 0 outside EXEC/WRITE.
- Run is ignored outside HALTED; there is no path back to HALTED except Reset.

Optional Feature:
- Macro: ALU_OP_SEQUENCER_STATS_EN.
- Defined: op_count increments at every WRITE cycle and saturates at 16'hFFFF. Illegal opcodes are not counted.
- Undefined: the op_count port remains, tied to 16'h0000, and no counter flops are synthesised.

Decomposition:
- Package slc3_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_ADD=4'b0001, OP_AND=4'b0101, OP_NOT=4'b1001;
  - ALUK encodings ALUK_ADD, ALUK_AND, ALUK_NOT, ALUK_PASS.
- Sub-module alu_op_decode (combinational): IR[15:12] and IR[5] in; ALUK, SR2MUX and legal out. Instantiated once.

Test Plan:
- Reset low mid-WRITE -> LD_REG drops immediately; NZP=000, IR=0; state HALTED until Run=1.
- Run=1, then IR_in=16'h1283 (ADD R1,R2,R3) with valid -> ALUK=11, SR2MUX=0; LD_REG high exactly at t+3; ALU_out=16'h0000 gives NZP=010.
- IR_in=16'h5262 (AND R1,R1,#2) -> ALUK=01, SR2MUX=1; ALU_out=16'h8000 gives NZP=100.
- IR_in=16'h927F (NOT) then back-to-back valid -> second instruction accepted exactly 4 cycles after the first; ALU_out=16'h0005 gives NZP=001.
- IR_in=16'hF025 (TRAP) -> illegal pulses 1 cycle in DECODE; no GateALU/LD_REG; op_count unchanged; instr_ready back next cycle.
- STEP_MODE=1, ADD issued -> PAUSE after WRITE; instr_ready=0 until Continue=1. With STATS_EN, 3 ops give op_count=3.
